periph_bus_arbiter: RTL and testbench
=====================================

Name: periph_bus_arbiter

Overview:
Two-master arbiter that shares the single memory-mapped peripheral bus (timer TH/TL/TCON, LED and digit registers at 0x4000_0000–0x4000_0014) between the CPU data port (M0) and a secondary master (M1, e.g. a UART/DMA engine). Each request is latched, driven onto the peripheral bus for exactly one cycle, and completed with a one-cycle ack plus registered read data. Sits between the CPU/M1 and the peripheral register block.

Parameters:
ADDR_W, 32, address width of masters and peripheral bus
DATA_W, 32, data width
FIXED_PRIO, 0, 0 = round-robin between M0/M1; 1 = M0 always wins ties

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
m0_req  in  1  M0 transaction request, held until m0_ack
m0_rd  in  1  M0 read command
m0_wr  in  1  M0 write command
m0_addr  in  ADDR_W  M0 address
m0_wdata  in  DATA_W  M0 write data
m0_ack  out  1  one-cycle completion pulse to M0
m0_rdata  out  DATA_W  read data, valid while m0_ack=1
m1_req, m1_rd, m1_wr, m1_addr, m1_wdata, m1_ack, m1_rdata  same as M0 for master 1
p_rd  out  1  peripheral read strobe
p_wr  out  1  peripheral write strobe
p_addr  out  ADDR_W  peripheral address
p_wdata  out  DATA_W  peripheral write data
p_rdata  in  DATA_W  peripheral combinational read data
busy  out  1  high in any state other than IDLE
owner  out  1  master currently/last granted (0 = M0, 1 = M1)

Behaviour:
- Single clock domain: clk; reset synchronous and active-high; all state updates on posedge clk.
- States: IDLE, XFER, RESP.
- IDLE: if neither req is high, stay. If one req is high, grant it. If both are high: FIXED_PRIO=1 -> M0; FIXED_PRIO=0 -> the master not equal to last_grant. On grant, latch rd/wr/addr/wdata of the winner into command registers, set owner and last_grant, go XFER.
- XFER (exactly 1 cycle):
  - p_addr and p_wdata are driven from the command registers.
  - If wr is set, p_wr=1; p_rd is forced 0 when both rd and wr are set (write wins).
  - If only rd is set, p_rd=1 and p_rdata is captured into the rdata register at the closing edge.
  - If neither rd nor wr is set, no strobe is driven but the transaction still completes.
  - Next state: RESP.
- RESP (1 cycle):
  - The owner's ack=1.
  - The owner's rdata = captured value for reads, 0 for writes or no-ops.
  - The non-owner's ack=0 and rdata=0.
  - req is ignored in this cycle. Next state: IDLE.
- Latency: req sampled high at edge 0 -> XFER in cycle 1 -> ack in cycle 2. Throughput is one transaction per 3 cycles.
- Master rule: req is deasserted in the cycle after ack. A req high in IDLE is always a new transaction.
- The losing master's req stays pending. It is granted at the next IDLE, so no starvation under round-robin.
- p_rd and p_wr are 0 in IDLE and RESP. p_addr and p_wdata hold their last values outside XFER (don't-care).
- m*_rdata are registered outputs and do not follow p_rdata combinationally.
- Reset (including mid-XFER or mid-RESP):
  - state=IDLE; p_rd=p_wr=0; p_addr=p_wdata=0.
  - Both acks 0; both rdata 0; busy=0.
  - owner=0; last_grant=1, so M0 wins the first tie.
  - An interrupted transaction is dropped with no ack. The master re-requests.
- A write interrupted during XFER may or may not land in the peripheral. The arbiter makes no guarantee.

Decomposition:
- Package periph_bus_pkg:
  - state enum {IDLE, XFER, RESP};
  - address constants ADDR_TH=0x4000_0000, ADDR_TL=0x4000_0004, ADDR_TCON=0x4000_0008, ADDR_LED=0x4000_000C, ADDR_DIGI=0x4000_0014;
  - a bus command struct (rd, wr, addr, wdata).
- One sub-module, periph_rr_pick: combinational 2-way winner select from req[1:0], last_grant and FIXED_PRIO. No other sub-modules.

Test Plan:
- Reset, then M0 write 0x4000_000C / 0x0000_00A5 -> p_wr=1 only in cycle 1 with that addr/data; m0_ack=1 only in cycle 2; m1_ack stays 0.
- M1 read 0x4000_0004 with p_rdata=0x1234_5678 during XFER -> m1_rdata=0x1234_5678 with m1_ack in cycle 2; p_rd high for exactly one cycle.
- FIXED_PRIO=0, both request simultaneously right after reset -> M0 acked at cycle 2 and M1 at cycle 5. A second simultaneous pair then serves M0 first again (last_grant=M1). Verifies alternation.
- FIXED_PRIO=1, M0 re-requests every IDLE while M1 waits -> M0 always granted while M0 requests in IDLE. M1 granted the first IDLE in which M0 req is low.
- M0 request with rd=wr=1, addr 0x4000_0008, wdata 0x5 -> p_wr=1, p_rd=0, m0_rdata=0 at ack.
- reset asserted during XFER of an M1 read -> next cycle state IDLE, p_rd=0, no m1_ack. M1 re-request completes normally in 3 cycles.

Source files
------------

// File: rtl/periph_bus_pkg.sv
// Shared types and register map for the two-master peripheral bus arbiter.
// The command struct is sized for the 32-bit peripheral bus.
package periph_bus_pkg;

  localparam int BUS_ADDR_W = 32;
  localparam int BUS_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [BUS_ADDR_W-1:0] ADDR_TH   = 32'h4000_0000;
  localparam logic [BUS_ADDR_W-1:0] ADDR_TL   = 32'h4000_0004;
  localparam logic [BUS_ADDR_W-1:0] ADDR_TCON = 32'h4000_0008;
  localparam logic [BUS_ADDR_W-1:0] ADDR_LED  = 32'h4000_000C;
  localparam logic [BUS_ADDR_W-1:0] ADDR_DIGI = 32'h4000_0014;

  typedef struct packed {
    logic                  rd;
    logic                  wr;
    logic [BUS_ADDR_W-1:0] addr;
    logic [BUS_DATA_W-1:0] wdata;
  } bus_cmd_t;

endpackage

// File: rtl/periph_rr_pick.sv
// Combinational two-way winner select: single requester wins outright,
// ties go to M0 (fixed priority) or to the master not granted last time.
module periph_rr_pick #(
  parameter int FIXED_PRIO = 0
) (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       valid,
  output logic       pick
);

  always_comb begin
    valid = |req;
    pick  = 1'b0;
    case (req)
      2'b10:   pick = 1'b1;
      2'b11:   pick = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant;
      default: pick = 1'b0;
    endcase
  end

endmodule

// File: rtl/periph_bus_arbiter.sv
// Shares the peripheral register bus between two masters: latch a request,
// drive it for one XFER cycle, then ack the owner with registered read data.
module periph_bus_arbiter
  import periph_bus_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_rd,
  input  logic              m0_wr,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_rd,
  input  logic              m1_wr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              p_rd,
  output logic              p_wr,
  output logic [ADDR_W-1:0] p_addr,
  output logic [DATA_W-1:0] p_wdata,
  input  logic [DATA_W-1:0] p_rdata,
  output logic              busy,
  output logic              owner,
  output state_t            state
);

  state_t            state_q, state_d;
  bus_cmd_t          cmd_q, win_cmd;
  logic              owner_q, last_grant_q;
  logic [DATA_W-1:0] rdata_q;
  logic              grant_valid, grant_pick;
  logic              in_xfer, in_resp;

  periph_rr_pick #(.FIXED_PRIO(FIXED_PRIO)) u_pick (
    .req       ({m1_req, m0_req}),
    .last_grant(last_grant_q),
    .valid     (grant_valid),
    .pick      (grant_pick)
  );

  always_comb begin
    win_cmd.rd    = grant_pick ? m1_rd : m0_rd;
    win_cmd.wr    = grant_pick ? m1_wr : m0_wr;
    win_cmd.addr  = grant_pick ? BUS_ADDR_W'(m1_addr) : BUS_ADDR_W'(m0_addr);
    win_cmd.wdata = grant_pick ? BUS_DATA_W'(m1_wdata) : BUS_DATA_W'(m0_wdata);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_valid) state_d = XFER;
      XFER:    state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cmd_q        <= '0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      rdata_q      <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && grant_valid) begin
        cmd_q        <= win_cmd;
        owner_q      <= grant_pick;
        last_grant_q <= grant_pick;
      end
      // Only a pure read returns data; writes and no-ops hand back zero.
      if (state_q == XFER)
        rdata_q <= (cmd_q.rd && !cmd_q.wr) ? p_rdata : '0;
    end
  end

  assign in_xfer  = (state_q == XFER);
  assign in_resp  = (state_q == RESP);
  assign p_wr     = in_xfer & cmd_q.wr;
  assign p_rd     = in_xfer & cmd_q.rd & ~cmd_q.wr;
  assign p_addr   = ADDR_W'(cmd_q.addr);
  assign p_wdata  = DATA_W'(cmd_q.wdata);
  assign m0_ack   = in_resp & ~owner_q;
  assign m1_ack   = in_resp & owner_q;
  assign m0_rdata = m0_ack ? rdata_q : '0;
  assign m1_rdata = m1_ack ? rdata_q : '0;
  assign busy     = (state_q != IDLE);
  assign owner    = owner_q;
  assign state    = state_q;

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Directed vector bench for periph_bus_arbiter: one round-robin and one
// fixed-priority instance share the same stimulus.
module tb_periph_bus_arbiter;
  import periph_bus_pkg::*;

  localparam logic [1:0] NOP = 2'b00, RD = 2'b01, WR = 2'b10, RW = 2'b11;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_rd, m0_wr, m1_req, m1_rd, m1_wr;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, p_rdata;

  logic        m0_ack_a, m1_ack_a, p_rd_a, p_wr_a, busy_a, owner_a;
  logic [31:0] m0_rdata_a, m1_rdata_a, p_addr_a, p_wdata_a;
  state_t      state_a;
  logic        m0_ack_b, m1_ack_b, p_rd_b, p_wr_b, busy_b, owner_b;
  logic [31:0] m0_rdata_b, m1_rdata_b, p_addr_b, p_wdata_b;
  state_t      state_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  periph_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(0)) dut_rr (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_rd(m0_rd), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack_a), .m0_rdata(m0_rdata_a),
    .m1_req(m1_req), .m1_rd(m1_rd), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack_a), .m1_rdata(m1_rdata_a),
    .p_rd(p_rd_a), .p_wr(p_wr_a), .p_addr(p_addr_a), .p_wdata(p_wdata_a), .p_rdata(p_rdata),
    .busy(busy_a), .owner(owner_a), .state(state_a)
  );

  periph_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(1)) dut_fp (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_rd(m0_rd), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack_b), .m0_rdata(m0_rdata_b),
    .m1_req(m1_req), .m1_rd(m1_rd), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack_b), .m1_rdata(m1_rdata_b),
    .p_rd(p_rd_b), .p_wr(p_wr_b), .p_addr(p_addr_b), .p_wdata(p_wdata_b), .p_rdata(p_rdata),
    .busy(busy_b), .owner(owner_b), .state(state_b)
  );

  // One row = one clock cycle: inputs driven during it, outputs expected during it.
  typedef struct {
    logic        rst;
    logic        r0;
    logic [1:0]  c0;
    logic [31:0] a0, d0;
    logic        r1;
    logic [1:0]  c1;
    logic [31:0] a1, d1;
    logic [31:0] prd;
    logic        sel;
    logic [1:0]  ack;
    logic [31:0] erd;
    logic [1:0]  str;
    logic        chkp;
    logic [31:0] pa, pw;
    logic        busy, own;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input logic r0, input logic [1:0] c0,
                              input logic [31:0] a0, input logic [31:0] d0,
                              input logic r1, input logic [1:0] c1,
                              input logic [31:0] a1, input logic [31:0] d1,
                              input logic [31:0] prd, input logic sel,
                              input logic [1:0] ack, input logic [31:0] erd,
                              input logic [1:0] str, input logic chkp,
                              input logic [31:0] pa, input logic [31:0] pw,
                              input logic busy, input logic own);
    vec_t v;
    v.rst = rst; v.r0 = r0; v.c0 = c0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.c1 = c1; v.a1 = a1; v.d1 = d1; v.prd = prd; v.sel = sel;
    v.ack = ack; v.erd = erd; v.str = str; v.chkp = chkp; v.pa = pa; v.pw = pw;
    v.busy = busy; v.own = own;
    return v;
  endfunction

  task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s row=%0d actual=%h required=%h", nm, row, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    reset    = v.rst;
    m0_req   = v.r0; m0_wr = v.c0[1]; m0_rd = v.c0[0]; m0_addr = v.a0; m0_wdata = v.d0;
    m1_req   = v.r1; m1_wr = v.c1[1]; m1_rd = v.c1[0]; m1_addr = v.a1; m1_wdata = v.d1;
    p_rdata  = v.prd;
  endtask

  task automatic check_row(input int i, input vec_t v);
    logic [1:0]  ack, str;
    logic [31:0] rd0, rd1, pa, pw;
    logic        bz, own;
    if (v.sel) begin
      ack = {m1_ack_b, m0_ack_b}; str = {p_wr_b, p_rd_b}; rd0 = m0_rdata_b; rd1 = m1_rdata_b;
      pa = p_addr_b; pw = p_wdata_b; bz = busy_b; own = owner_b;
    end else begin
      ack = {m1_ack_a, m0_ack_a}; str = {p_wr_a, p_rd_a}; rd0 = m0_rdata_a; rd1 = m1_rdata_a;
      pa = p_addr_a; pw = p_wdata_a; bz = busy_a; own = owner_a;
    end
    chk("ack", i, 32'(ack), 32'(v.ack));
    chk("strobe", i, 32'(str), 32'(v.str));
    chk("m0_rdata", i, rd0, v.ack[0] ? v.erd : 32'h0);
    chk("m1_rdata", i, rd1, v.ack[1] ? v.erd : 32'h0);
    chk("busy", i, 32'(bz), 32'(v.busy));
    chk("owner", i, 32'(own), 32'(v.own));
    if (v.chkp) begin
      chk("p_addr", i, pa, v.pa);
      chk("p_wdata", i, pw, v.pw);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit got;
    // reset state
    vecs.push_back(mk(0, 0,NOP,0,0, 0,NOP,0,0, 0, 0, 2'b00,0, 2'b00, 1,0,0, 0,0));
    // M0 write LED
    vecs.push_back(mk(0, 1,WR,ADDR_LED,32'hA5, 0,NOP,0,0, 0, 0, 2'b00,0, 2'b00, 0,0,0, 0,0));
    vecs.push_back(mk(0, 1,WR,ADDR_LED,32'hA5, 0,NOP,0,0, 0, 0, 2'b00,0, 2'b10, 1,ADDR_LED,32'hA5, 1,0));
    vecs.push_back(mk(0, 1,WR,ADDR_LED,32'hA5, 0,NOP,0,0, 0, 0, 2'b01,0, 2'b00, 0,0,0, 1,0));
    vecs.push_back(mk(0, 0,NOP,0,0, 0,NOP,0,0, 0, 0, 2'b00,0, 2'b00, 0,0,0, 0,0));
    // M1 read TL; p_rdata changes in RESP to show rdata is registered
    vecs.push_back(mk(0, 0,NOP,0,0, 1,RD,ADDR_TL,0, 0, 0, 2'b00,0, 2'b00, 0,0,0, 0,0));
    vecs.push_back(mk(0, 0,NOP,0,0, 1,RD,ADDR_TL,0, 32'h1234_5678, 0, 2'b00,0, 2'b01, 1,ADDR_TL,0, 1,1));
    vecs.push_back(mk(0, 0,NOP,0,0, 1,RD,ADDR_TL,0, 32'hDEAD_BEEF, 0, 2'b10,32'h1234_5678, 2'b00, 0,0,0, 1,1));
    vecs.push_back(mk(0, 0,NOP,0,0, 0,NOP,0,0, 0, 0, 2'b00,0, 2'b00, 0,0,0, 0,1));
    // round-robin tie right after reset, then a second tie
    vecs.push_back(mk(1, 0,NOP,0,0, 0,NOP,0,0, 0, 0, 2'b00,0, 2'b00, 0,0,0, 0,1));
    vecs.push_back(mk(0, 1,WR,ADDR_TH,1, 1,WR,ADDR_TCON,2, 0, 0, 2'b00,0, 2'b00, 0,0,0, 0,0));
    vecs.push_back(mk(0, 1,WR,ADDR_TH,1, 1,WR,ADDR_TCON,2, 0, 0, 2'b00,0, 2'b10, 1,ADDR_TH,1, 1,0));
    vecs.push_back(mk(0, 1,WR,ADDR_TH,1, 1,WR,ADDR_TCON,2, 0, 0, 2'b01,0, 2'b00, 0,0,0, 1,0));
    vecs.push_back(mk(0, 0,NOP,0,0, 1,WR,ADDR_TCON,2, 0, 0, 2'b00,0, 2'b00, 0,0,0, 0,0));
    vecs.push_back(mk(0, 0,NOP,0,0, 1,WR,ADDR_TCON,2, 0, 0, 2'b00,0, 2'b10, 1,ADDR_TCON,2, 1,1));
    vecs.push_back(mk(0, 0,NOP,0,0, 1,WR,ADDR_TCON,2, 0, 0, 2'b10,0, 2'b00, 0,0,0, 1,1));
    vecs.push_back(mk(0, 1,RD,ADDR_DIGI,0, 1,WR,ADDR_TCON,2, 0, 0, 2'b00,0, 2'b00, 0,0,0, 0,1));
    vecs.push_back(mk(0, 1,RD,ADDR_DIGI,0, 1,WR,ADDR_TCON,2, 32'hCAFE_0001, 0, 2'b00,0, 2'b01, 1,ADDR_DIGI,0, 1,0));
    vecs.push_back(mk(0, 1,RD,ADDR_DIGI,0, 1,WR,ADDR_TCON,2, 0, 0, 2'b01,32'hCAFE_0001, 2'b00, 0,0,0, 1,0));
    vecs.push_back(mk(0, 0,NOP,0,0, 1,WR,ADDR_TCON,2, 0, 0, 2'b00,0, 2'b00, 0,0,0, 0,0));
    vecs.push_back(mk(0, 0,NOP,0,0, 1,WR,ADDR_TCON,2, 0, 0, 2'b00,0, 2'b10, 1,ADDR_TCON,2, 1,1));
    vecs.push_back(mk(0, 0,NOP,0,0, 1,WR,ADDR_TCON,2, 0, 0, 2'b10,0, 2'b00, 0,0,0, 1,1));
    vecs.push_back(mk(0, 0,NOP,0,0, 0,NOP,0,0, 0, 0, 2'b00,0, 2'b00, 0,0,0, 0,1));
    // fixed priority: M0 re-requests while M1 waits
    vecs.push_back(mk(1, 0,NOP,0,0, 0,NOP,0,0, 0, 1, 2'b00,0, 2'b00, 0,0,0, 0,1));
    vecs.push_back(mk(0, 1,WR,ADDR_LED,3, 1,RD,ADDR_TH,0, 0, 1, 2'b00,0, 2'b00, 0,0,0, 0,0));
    vecs.push_back(mk(0, 1,WR,ADDR_LED,3, 1,RD,ADDR_TH,0, 0, 1, 2'b00,0, 2'b10, 1,ADDR_LED,3, 1,0));
    vecs.push_back(mk(0, 1,WR,ADDR_LED,3, 1,RD,ADDR_TH,0, 0, 1, 2'b01,0, 2'b00, 0,0,0, 1,0));
    vecs.push_back(mk(0, 1,WR,ADDR_LED,4, 1,RD,ADDR_TH,0, 0, 1, 2'b00,0, 2'b00, 0,0,0, 0,0));
    vecs.push_back(mk(0, 1,WR,ADDR_LED,4, 1,RD,ADDR_TH,0, 0, 1, 2'b00,0, 2'b10, 1,ADDR_LED,4, 1,0));
    vecs.push_back(mk(0, 1,WR,ADDR_LED,4, 1,RD,ADDR_TH,0, 0, 1, 2'b01,0, 2'b00, 0,0,0, 1,0));
    vecs.push_back(mk(0, 0,NOP,0,0, 1,RD,ADDR_TH,0, 0, 1, 2'b00,0, 2'b00, 0,0,0, 0,0));
    vecs.push_back(mk(0, 0,NOP,0,0, 1,RD,ADDR_TH,0, 32'h55AA, 1, 2'b00,0, 2'b01, 1,ADDR_TH,0, 1,1));
    vecs.push_back(mk(0, 0,NOP,0,0, 1,RD,ADDR_TH,0, 0, 1, 2'b10,32'h55AA, 2'b00, 0,0,0, 1,1));
    vecs.push_back(mk(0, 0,NOP,0,0, 0,NOP,0,0, 0, 1, 2'b00,0, 2'b00, 0,0,0, 0,1));
    // rd=wr=1 (write wins, rdata 0), then a no-op from M1
    vecs.push_back(mk(1, 0,NOP,0,0, 0,NOP,0,0, 0, 0, 2'b00,0, 2'b00, 0,0,0, 0,1));
    vecs.push_back(mk(0, 1,RW,ADDR_TCON,5, 0,NOP,0,0, 0, 0, 2'b00,0, 2'b00, 0,0,0, 0,0));
    vecs.push_back(mk(0, 1,RW,ADDR_TCON,5, 0,NOP,0,0, 32'hFFFF_FFFF, 0, 2'b00,0, 2'b10, 1,ADDR_TCON,5, 1,0));
    vecs.push_back(mk(0, 1,RW,ADDR_TCON,5, 0,NOP,0,0, 0, 0, 2'b01,0, 2'b00, 0,0,0, 1,0));
    vecs.push_back(mk(0, 0,NOP,0,0, 0,NOP,0,0, 0, 0, 2'b00,0, 2'b00, 0,0,0, 0,0));
    vecs.push_back(mk(0, 0,NOP,0,0, 1,NOP,ADDR_DIGI,32'h77, 0, 0, 2'b00,0, 2'b00, 0,0,0, 0,0));
    vecs.push_back(mk(0, 0,NOP,0,0, 1,NOP,ADDR_DIGI,32'h77, 32'h1111, 0, 2'b00,0, 2'b00, 1,ADDR_DIGI,32'h77, 1,1));
    vecs.push_back(mk(0, 0,NOP,0,0, 1,NOP,ADDR_DIGI,32'h77, 0, 0, 2'b10,0, 2'b00, 0,0,0, 1,1));
    vecs.push_back(mk(0, 0,NOP,0,0, 0,NOP,0,0, 0, 0, 2'b00,0, 2'b00, 0,0,0, 0,1));

    // clock/reset
    drive(mk(1, 0,NOP,0,0, 0,NOP,0,0, 0, 0, 0,0, 0, 0,0,0, 0,0));
    repeat (2) @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      check_row(i, vecs[i]);
    end

    // reset lands while an M1 read is in XFER
    @(negedge clk);
    drive(mk(0, 0,NOP,0,0, 1,RD,ADDR_LED,0, 0, 0, 0,0, 0, 0,0,0, 0,0));
    @(negedge clk);
    reset = 1'b1; p_rdata = 32'h0000_ABCD;
    #1;
    chk("rst_state_xfer", 100, 32'(state_a), 32'(XFER));
    chk("rst_p_rd_xfer", 100, 32'(p_rd_a), 32'h1);
    @(negedge clk);
    reset = 1'b0; p_rdata = 32'h0BAD_F00D;
    #1;
    chk("rst_state_idle", 101, 32'(state_a), 32'(IDLE));
    chk("rst_p_rd", 101, 32'(p_rd_a), 32'h0);
    chk("rst_m1_ack", 101, 32'(m1_ack_a), 32'h0);
    chk("rst_busy", 101, 32'(busy_a), 32'h0);
    chk("rst_owner", 101, 32'(owner_a), 32'h0);
    chk("rst_p_addr", 101, p_addr_a, 32'h0);

    // M1 keeps requesting; ack expected two cycles later
    n = 0;
    got = 1'b0;
    while (!got && n < 8) begin
      @(negedge clk);
      #1;
      n++;
      if (m1_ack_a) got = 1'b1;
    end
    chk("rereq_latency", 102, 32'(n), 32'd2);
    chk("rereq_rdata", 102, m1_rdata_a, 32'h0BAD_F00D);
    m1_req = 1'b0;
    @(negedge clk);
    #1;
    chk("rereq_idle", 103, 32'(busy_a), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
